// File: rtl/tx_serial_8n1.sv
// 8N1 UART transmitter: internal bit-period counter, frame shift register and control FSM.
// Define TX_SERIAL_PARIDADE_EN to send 8E1 frames, with an even-parity bit between D7 and stop.

// state          | meaning
// ST_INICIAL     | idle, line high, waiting for partida
// ST_TRANSMISSAO | shifting the frame out, CLKS_PER_BIT cycles per bit
// ST_FINAL       | one-cycle pronto pulse, partida ignored

module tx_serial_8n1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados_ascii,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto
);

`ifdef TX_SERIAL_PARIDADE_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_INICIAL,
        ST_TRANSMISSAO,
        ST_FINAL
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      tick_cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] frame_load;

    // Frame is sent LSB first: start bit sits in bit 0, stop bit in the MSB.
`ifdef TX_SERIAL_PARIDADE_EN
    assign frame_load = {1'b1, ^dados_ascii, dados_ascii, 1'b0};
`else
    assign frame_load = {1'b1, dados_ascii, 1'b0};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_INICIAL;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '1;
            saida_serial <= 1'b1;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            case (state)
                ST_INICIAL: begin
                    pronto       <= 1'b0;
                    saida_serial <= 1'b1;
                    if (partida) begin
                        shreg        <= frame_load;
                        tick_cnt     <= '0;
                        bit_cnt      <= '0;
                        saida_serial <= 1'b0;
                        ocupado      <= 1'b1;
                        state        <= ST_TRANSMISSAO;
                    end
                end

                ST_TRANSMISSAO: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        bit_cnt  <= bit_cnt + 4'd1;
                        shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            saida_serial <= 1'b1;
                            ocupado      <= 1'b0;
                            pronto       <= 1'b1;
                            state        <= ST_FINAL;
                        end else begin
                            // Drive the bit that becomes the new LSB after this shift.
                            saida_serial <= shreg[1];
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                ST_FINAL: begin
                    pronto       <= 1'b0;
                    ocupado      <= 1'b0;
                    saida_serial <= 1'b1;
                    state        <= ST_INICIAL;
                end

                default: begin
                    saida_serial <= 1'b1;
                    ocupado      <= 1'b0;
                    pronto       <= 1'b0;
                    state        <= ST_INICIAL;
                end
            endcase
        end
    end

endmodule
